// File: rtl/id_stage_decode_buffer_pkg.sv
// id_stage_decode_buffer_pkg: opcodes, field ranges and entry types shared with the control unit
package id_stage_decode_buffer_pkg;
   localparam int XLEN = 32;
   localparam int OPC_HI = 31, OPC_LO = 26;
   localparam int RS_HI = 25, RS_LO = 21;
   localparam int RT_HI = 20, RT_LO = 16;
   localparam int RD_HI = 15, RD_LO = 11;
   localparam int SH_HI = 10, SH_LO = 6;
   localparam int FN_HI = 5, FN_LO = 0;
   localparam int IMM_HI = 15, IMM_LO = 0;
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_BLEZ  = 6'h06;
   localparam logic [5:0] OP_BGTZ  = 6'h07;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LB    = 6'h20;
   localparam logic [5:0] OP_LH    = 6'h21;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_LBU   = 6'h24;
   localparam logic [5:0] OP_LHU   = 6'h25;
   localparam logic [5:0] OP_SB    = 6'h28;
   localparam logic [5:0] OP_SH    = 6'h29;
   localparam logic [5:0] OP_SW    = 6'h2B;
   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc4;
   } entry_t;
   typedef struct packed {
      logic imm_signed;
      logic illegal;
      logic is_rtype;
   } imm_class_t;
endpackage

// File: rtl/id_stage_decode_buffer_imm_class_decode.sv
// id_stage_decode_buffer_imm_class_decode: opcode to immediate-extension class and legality
module id_stage_decode_buffer_imm_class_decode
   import id_stage_decode_buffer_pkg::*;
(
   input  logic [5:0]  opcode_i,
   output imm_class_t  cls_o
);
   always_comb begin
      cls_o = '0;
      case (opcode_i)
         OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
         OP_SB, OP_SH, OP_SW:                          cls_o.imm_signed = 1'b1;
         OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_J, OP_JAL: cls_o.illegal = 1'b0;
         OP_RTYPE:                                     cls_o.is_rtype = 1'b1;
         default:                                      cls_o.illegal = 1'b1;
      endcase
   end
endmodule

// File: rtl/id_stage_decode_buffer.sv
// id_stage_decode_buffer: decode-stage register with 2-entry skid buffer feeding the imm extender
module id_stage_decode_buffer
   import id_stage_decode_buffer_pkg::*;
#(
   parameter int DATA_W = XLEN,
   parameter int IMM_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] instr_in,
   input  logic [DATA_W-1:0] pc4_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [5:0]        opcode,
   output logic [4:0]        rs,
   output logic [4:0]        rt,
   output logic [4:0]        rd,
   output logic [4:0]        shamt,
   output logic [5:0]        funct,
   output logic [IMM_W-1:0]  imm,
   output logic              imm_signed,
   output logic              is_rtype,
   output logic              illegal,
   output logic [DATA_W-1:0] pc4_out
);
   entry_t     m_q, m_d, s_q, s_d, in_e;
   logic       in_ready_q, in_ready_d, acc, cons;
   imm_class_t cls;

   assign in_e = '{valid: 1'b1, instr: instr_in, pc4: pc4_in};
   assign acc  = in_valid & in_ready_q;
   assign cons = m_q.valid & out_ready;

   always_comb begin
      m_d = m_q;
      s_d = s_q;
      if (flush) begin
         m_d.valid = 1'b0;
         s_d.valid = 1'b0;
      end else if (!m_q.valid || cons) begin
         if (s_q.valid) begin
            m_d = s_q;
            s_d = acc ? in_e : '{valid: 1'b0, instr: s_q.instr, pc4: s_q.pc4};
         end else if (acc) begin
            m_d = in_e;
         end else begin
            m_d.valid = 1'b0;
         end
      end else if (acc) begin
         s_d = in_e;
      end
      in_ready_d = !s_d.valid;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q        <= '0;
         s_q        <= '0;
         in_ready_q <= 1'b1;
      end else begin
         m_q        <= m_d;
         s_q        <= s_d;
         in_ready_q <= in_ready_d;
      end
   end

   id_stage_decode_buffer_imm_class_decode u_cls (
      .opcode_i (opcode),
      .cls_o    (cls)
   );

   // class flags are qualified so an empty stage reports no class
   assign in_ready   = in_ready_q;
   assign out_valid  = m_q.valid;
   assign opcode     = m_q.instr[OPC_HI:OPC_LO];
   assign rs         = m_q.instr[RS_HI:RS_LO];
   assign rt         = m_q.instr[RT_HI:RT_LO];
   assign rd         = m_q.instr[RD_HI:RD_LO];
   assign shamt      = m_q.instr[SH_HI:SH_LO];
   assign funct      = m_q.instr[FN_HI:FN_LO];
   assign imm        = m_q.instr[IMM_HI:IMM_LO];
   assign imm_signed = m_q.valid & cls.imm_signed;
   assign is_rtype   = m_q.valid & cls.is_rtype;
   assign illegal    = m_q.valid & cls.illegal;
   assign pc4_out    = m_q.pc4;
endmodule

// File: tb/tb_id_stage_decode_buffer.sv
// tb_id_stage_decode_buffer: directed vector table plus backpressure, flush and reset sequences
module tb_id_stage_decode_buffer;
   logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic        in_ready, out_valid, imm_signed, is_rtype, illegal;
   logic [31:0] instr_in = '0, pc4_in = '0, pc4_out;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm;
   int          checks = 0, errors = 0;

   id_stage_decode_buffer dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .instr_in(instr_in), .pc4_in(pc4_in), .out_valid(out_valid), .out_ready(out_ready),
      .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm(imm),
      .imm_signed(imm_signed), .is_rtype(is_rtype), .illegal(illegal), .pc4_out(pc4_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [5:0]  op;
      logic [4:0]  rs, rt, rd, sh;
      logic [5:0]  fn;
      logic [15:0] imm;
      logic        sg, il, rty;
   } vec_t;
   vec_t tv[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] ins, input logic [31:0] pc);
      in_valid = 1'b1;
      instr_in = ins;
      pc4_in   = pc;
   endtask

   initial begin
      tv[0] = '{32'h2008FFFF, 6'h08, 5'd0, 5'd8,  5'd31, 5'd31, 6'h3F, 16'hFFFF, 1'b1, 1'b0, 1'b0};
      tv[1] = '{32'h3508FFFF, 6'h0D, 5'd8, 5'd8,  5'd31, 5'd31, 6'h3F, 16'hFFFF, 1'b0, 1'b0, 1'b0};
      tv[2] = '{32'h012A4020, 6'h00, 5'd9, 5'd10, 5'd8,  5'd0,  6'h20, 16'h4020, 1'b0, 1'b0, 1'b1};
      tv[3] = '{32'hFC000000, 6'h3F, 5'd0, 5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 1'b0, 1'b1, 1'b0};
      tv[4] = '{32'hAC0B0010, 6'h2B, 5'd0, 5'd11, 5'd0,  5'd0,  6'h10, 16'h0010, 1'b1, 1'b0, 1'b0};
      tv[5] = '{32'h3C01ABCD, 6'h0F, 5'd0, 5'd1,  5'd21, 5'd15, 6'h0D, 16'hABCD, 1'b0, 1'b0, 1'b0};
      tv[6] = '{32'h08000010, 6'h02, 5'd0, 5'd0,  5'd0,  5'd0,  6'h10, 16'h0010, 1'b0, 1'b0, 1'b0};
      tv[7] = '{32'h10220005, 6'h04, 5'd1, 5'd2,  5'd0,  5'd0,  6'h05, 16'h0005, 1'b1, 1'b0, 1'b0};
      tv[8] = '{32'h04000000, 6'h01, 5'd0, 5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 1'b0, 1'b1, 1'b0};
      tv[9] = '{32'h8C010000, 6'h23, 5'd0, 5'd1,  5'd0,  5'd0,  6'h00, 16'h0000, 1'b1, 1'b0, 1'b0};

      #12;
      chk("reset out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset pc4_out", pc4_out, 32'd0);
      rst_n = 1'b1;
      step();
      chk("post-reset in_ready", {31'd0, in_ready}, 32'd1);
      chk("post-reset out_valid", {31'd0, out_valid}, 32'd0);

      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         push(tv[i].instr, 32'h4 * (i + 1));
         step();
         in_valid = 1'b0;
         chk($sformatf("v%0d out_valid", i), {31'd0, out_valid}, 32'd1);
         chk($sformatf("v%0d opcode", i), {26'd0, opcode}, {26'd0, tv[i].op});
         chk($sformatf("v%0d rs", i), {27'd0, rs}, {27'd0, tv[i].rs});
         chk($sformatf("v%0d rt", i), {27'd0, rt}, {27'd0, tv[i].rt});
         chk($sformatf("v%0d rd", i), {27'd0, rd}, {27'd0, tv[i].rd});
         chk($sformatf("v%0d shamt", i), {27'd0, shamt}, {27'd0, tv[i].sh});
         chk($sformatf("v%0d funct", i), {26'd0, funct}, {26'd0, tv[i].fn});
         chk($sformatf("v%0d imm", i), {16'd0, imm}, {16'd0, tv[i].imm});
         chk($sformatf("v%0d imm_signed", i), {31'd0, imm_signed}, {31'd0, tv[i].sg});
         chk($sformatf("v%0d illegal", i), {31'd0, illegal}, {31'd0, tv[i].il});
         chk($sformatf("v%0d is_rtype", i), {31'd0, is_rtype}, {31'd0, tv[i].rty});
         chk($sformatf("v%0d pc4_out", i), pc4_out, 32'h4 * (i + 1));
      end
      step();
      chk("drain out_valid", {31'd0, out_valid}, 32'd0);

      // backpressure: A, B buffered, C held off until a slot frees
      out_ready = 1'b0;
      push(32'h8C010000, 32'h100);
      step();
      push(32'h8C020004, 32'h104);
      step();
      chk("bp in_ready after B", {31'd0, in_ready}, 32'd0);
      push(32'h8C030008, 32'h108);
      step();
      chk("bp in_ready C held", {31'd0, in_ready}, 32'd0);
      chk("bp hold A pc4", pc4_out, 32'h100);
      chk("bp hold A rt", {27'd0, rt}, 32'd1);
      out_ready = 1'b1;
      step();
      chk("bp B valid", {31'd0, out_valid}, 32'd1);
      chk("bp B pc4", pc4_out, 32'h104);
      chk("bp B rt", {27'd0, rt}, 32'd2);
      step();
      in_valid = 1'b0;
      chk("bp C pc4", pc4_out, 32'h108);
      chk("bp C rt", {27'd0, rt}, 32'd3);
      step();
      chk("bp drained", {31'd0, out_valid}, 32'd0);

      // flush with A, B buffered and D offered in the same cycle
      out_ready = 1'b0;
      push(32'h8C010000, 32'h300);
      step();
      push(32'h8C020004, 32'h304);
      step();
      chk("fl full in_ready", {31'd0, in_ready}, 32'd0);
      push(32'h8C0400FF, 32'h30C);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("fl out_valid", {31'd0, out_valid}, 32'd0);
      chk("fl in_ready", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      chk("fl D absent", {31'd0, out_valid}, 32'd0);

      // asynchronous reset with both entries full
      out_ready = 1'b0;
      push(32'h8C010000, 32'h400);
      step();
      push(32'h8C020004, 32'h404);
      step();
      in_valid = 1'b0;
      chk("rst pre full", {31'd0, in_ready}, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("rst async out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst async in_ready", {31'd0, in_ready}, 32'd1);
      #2 rst_n = 1'b1;
      step();
      out_ready = 1'b1;
      push(32'h2008FFFF, 32'h500);
      step();
      in_valid = 1'b0;
      chk("rst first out valid", {31'd0, out_valid}, 32'd1);
      chk("rst first out pc4", pc4_out, 32'h500);
      step();
      chk("rst no stale entry", {31'd0, out_valid}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/id_stage_decode_buffer.md
Name: id_stage_decode_buffer

Overview:
- Instruction-decode pipeline stage between instruction fetch and the 16→32-bit immediate sign extender / register file.
- Registers each fetched 32-bit instruction and its PC+4, splits out the fields, and classifies the immediate as signed or zero-extended.
- Drives the extender's 16-bit input and its Signed select directly.
- Valid/ready handshakes on both sides, with a 2-entry skid buffer so stalls never lose data and full throughput is kept.

Parameters:
- DATA_W, 32, instruction and PC width (only 32 supported)
- IMM_W, 16, immediate field width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- flush  in  1  synchronous kill of all buffered entries (branch/jump redirect)
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage can accept this cycle
- instr_in  in  32  instruction word
- pc4_in  in  32  PC+4 of the instruction
- out_valid  out  1  decoded entry available
- out_ready  in  1  downstream consumes this cycle
- opcode  out  6  instr[31:26]
- rs  out  5  instr[25:21]
- rt  out  5  instr[20:16]
- rd  out  5  instr[15:11]
- shamt  out  5  instr[10:6]
- funct  out  6  instr[5:0]
- imm  out  16  instr[15:0], to the sign extender X input
- imm_signed  out  1  to the sign extender Signed input
- is_rtype  out  1  opcode == 0
- illegal  out  1  opcode not in the supported set
- pc4_out  out  32  registered PC+4

Behaviour:
- Reset (rst_n low, asynchronous):
  - all outputs and both buffer entries clear to 0
  - in_ready = 1 from the first cycle after release
- Storage:
  - main entry M drives all outputs
  - skid entry S holds at most one extra entry
  - in_ready is a register, equal to !S.valid
- Accept: in_valid && in_ready at the clock edge.
- Consume: out_valid && out_ready at the clock edge.
- Per-edge rules, evaluated in order:
  - M empty, or M consumed: M <= S if S valid, else M <= input if accepted; S <= input if S was valid and an input was accepted.
  - M held (not consumed), input accepted: S <= input.
- Latency and throughput:
  - accepted instruction appears on outputs the next cycle (1-cycle latency)
  - sustained 1 instruction/cycle while out_ready is high
  - FIFO order is always preserved
- Decode:
  - combinational from the stored word, or computed at capture and stored; either way it must be valid in the same cycle as out_valid.
- imm_signed = 1 for these opcodes:
  - BEQ 0x04, BNE 0x05, BLEZ 0x06, BGTZ 0x07
  - ADDI 0x08, ADDIU 0x09, SLTI 0x0A, SLTIU 0x0B
  - LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25
  - SB 0x28, SH 0x29, SW 0x2B
- imm_signed = 0 for:
  - ANDI 0x0C, ORI 0x0D, XORI 0x0E, LUI 0x0F
  - R-type 0x00, J 0x02, JAL 0x03
- illegal = 1 for any other opcode; imm_signed is then 0. The entry still flows; trap handling is downstream.
- Field outputs are meaningful only while out_valid = 1. When empty they hold the last value, and the bench must not check them then.
- flush:
  - At the edge where flush = 1, M and S are invalidated and in_ready becomes 1.
  - An input accepted in the same cycle is discarded.
  - A consume in the same cycle is still counted downstream (output was valid before the edge).
- Invariants:
  - in_valid held with in_ready = 0 causes no state change
  - out_ready is ignored while out_valid = 0
- Reset asserted mid-stream drops all entries asynchronously; no partial state survives.

Decomposition:
- Shared package: opcode localparams (OP_RTYPE, OP_ADDI, OP_ORI, OP_LW, …) and field bit-range constants; these are shared with the control unit.
- Sub-module imm_class_decode: pure combinational, opcode → {imm_signed, illegal, is_rtype}. Instantiated once on M's word.
- The handshake/skid logic stays in the top module.

Test Plan:
- Reset release, then in_valid with instr 0x2008FFFF, pc4 0x00000004, out_ready = 1 → next cycle: out_valid = 1, opcode 0x08, rt 8, imm 0xFFFF, imm_signed 1, illegal 0, pc4_out 0x00000004.
- instr 0x3508FFFF (ORI) → imm_signed 0, imm 0xFFFF. Instr 0x012A4020 (ADD) → is_rtype 1, rs 9, rt 10, rd 8, funct 0x20, imm_signed 0.
- Backpressure:
  - stimulus: out_ready = 0; push A = 0x8C010000 and B = 0x8C020004 on consecutive cycles
  - in_ready drops to 0 after B is accepted; a C held on the input is not taken
  - raising out_ready yields A, then B, then C on consecutive cycles with no loss or duplication
- Flush: buffer holds A and B; assert flush with in_valid = 1 for D → next cycle out_valid = 0 and in_ready = 1; D never appears.
- Opcode 0x3F → illegal 1, imm_signed 0, entry still delivered. Opcode 0x2B (SW) → imm_signed 1.
- rst_n pulsed low mid-stream with both entries full → out_valid = 0 and in_ready = 1 immediately (asynchronous); the first post-reset instruction is the next one output.
